// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU codes, FSM states and mux encodings for the multicycle controller
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_OR   = 3'b111
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JR       = 4'd11,
        S_JUMP     = 4'd12,
        S_FAULT    = 4'd13
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_RS   = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] B_RT      = 2'd0;
    localparam logic [1:0] B_FOUR    = 2'd1;
    localparam logic [1:0] B_IMM     = 2'd2;
    localparam logic [1:0] B_IMM_SH2 = 2'd3;

    function automatic logic r_funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic alu_op_t r_alu_op(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - consecutive not-ready cycle counter for the memory handshake
// clk, reset : clock, async active-high reset
// clr        : zero the count (takes priority over en)
// en         : count one more not-ready cycle
// expired    : the current not-ready cycle is the last one allowed
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // cnt holds the not-ready cycles already spent, so the limit is hit
    // while the MEM_TIMEOUT-th one is in progress.
    generate
        if (MEM_TIMEOUT > 0) begin : g_limit
            assign expired = (cnt == W'(MEM_TIMEOUT - 1));
        end else begin : g_nolimit
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset control FSM with memory timeout and perf counters
// in : clk, reset (async, active-high), opcode, funct, zero, mem_ready
// out: pc_wr, pc_src, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
//      alu_src_a, alu_src_b, alu_op, fault, cycle_cnt, instr_cnt
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter bit SUPPORT_JAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             ir_wr,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t state, next_state;
    logic   in_mem, expired, timeout, is_jal;

    assign in_mem  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign is_jal  = SUPPORT_JAL && (opcode == OP_JAL);
    assign timeout = in_mem && !mem_ready && expired;

    // Not counting outside memory states and on completion leaves the count
    // at zero whenever a memory state is entered.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clr     (!in_mem || mem_ready),
        .en      (in_mem && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR)         next_state = S_JR;
                        else if (r_funct_ok(funct)) next_state = S_EXEC_R;
                        else                        next_state = S_FAULT;
                    end
                    OP_ADDI, OP_XORI: next_state = S_EXEC_I;
                    OP_LW, OP_SW:     next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:   next_state = S_BRANCH;
                    OP_J:             next_state = S_JUMP;
                    OP_JAL: begin
                        if (SUPPORT_JAL) next_state = S_JUMP;
                        else             next_state = S_FAULT;
                    end
                    default:          next_state = S_FAULT;
                endcase
            end
            S_EXEC_R:   next_state = S_WB_R;
            S_WB_R:     next_state = S_FETCH;
            S_EXEC_I:   next_state = S_WB_I;
            S_WB_I:     next_state = S_FETCH;
            S_MEM_ADDR: begin
                if (opcode == OP_LW) next_state = S_MEM_RD;
                else                 next_state = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready)    next_state = S_MEM_WB;
                else if (timeout) next_state = S_FAULT;
            end
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_FAULT;
            end
            S_BRANCH:   next_state = S_FETCH;
            S_JR:       next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            S_FAULT:    next_state = S_FAULT;
            default:    next_state = S_FAULT;
        endcase
    end

    // The IR is only loaded in FETCH, so opcode/funct stay stable through
    // the rest of the instruction and may steer the per-state decode.
    always_comb begin
        pc_wr      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        ir_wr      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = B_RT;
        alu_op     = ALU_ADD;
        fault      = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_rd    = 1'b1;
                    alu_src_b = B_FOUR;
                    ir_wr     = mem_ready;
                    pc_wr     = mem_ready;
                end
                S_DECODE:   alu_src_b = B_IMM_SH2;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = r_alu_op(funct);
                end
                S_WB_R: begin
                    reg_wr  = 1'b1;
                    reg_dst = DST_RD;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = B_IMM;
                    alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                end
                S_WB_I:     reg_wr = 1'b1;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = B_IMM;
                end
                S_MEM_RD: begin
                    mem_rd = 1'b1;
                    iord   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_wr     = 1'b1;
                    mem_to_reg = M2R_MEM;
                end
                S_MEM_WR: begin
                    mem_wr = 1'b1;
                    iord   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_SRC_BR;
                    pc_wr     = (opcode == OP_BNE) ? !zero : zero;
                end
                S_JR: begin
                    pc_wr  = 1'b1;
                    pc_src = PC_SRC_RS;
                end
                S_JUMP: begin
                    pc_wr  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                    if (is_jal) begin
                        reg_wr     = 1'b1;
                        reg_dst    = DST_R31;
                        mem_to_reg = M2R_PC;
                    end
                end
                S_FAULT:    fault = 1'b1;
                default:    fault = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state != S_FAULT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            // FETCH waiting on itself is not a retirement; FAULT never reaches FETCH.
            if ((state != S_FETCH) && (next_state == S_FETCH)) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven bench for multicycle_controller
module tb_multicycle_controller;

    localparam int OPR = 6'h00, OPJAL = 6'h03, OPBEQ = 6'h04, OPBNE = 6'h05;
    localparam int OPXORI = 6'h0E, OPLW = 6'h23, OPSW = 6'h2B, OPBAD = 6'h3F;
    localparam int FADD = 6'h20, FSUB = 6'h22, FOR = 6'h25, FJR = 6'h08;

    logic clk, reset, zero, mem_ready;
    logic [5:0] opcode, funct;

    logic pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, alu_src_a, fault;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0] alu_op;
    logic [31:0] cycle_cnt, instr_cnt;

    logic pc_wr2, ir_wr2, iord2, mem_rd2, mem_wr2, reg_wr2, alu_src_a2, fault2;
    logic [1:0] pc_src2, reg_dst2, mem_to_reg2, alu_src_b2;
    logic [2:0] alu_op2;
    logic [31:0] cycle_cnt2, instr_cnt2;

    multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(8), .SUPPORT_JAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
        .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .fault(fault),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(8), .SUPPORT_JAL(1'b0)) dut_nojal (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_wr(pc_wr2), .pc_src(pc_src2), .ir_wr(ir_wr2),
        .iord(iord2), .mem_rd(mem_rd2), .mem_wr(mem_wr2), .reg_wr(reg_wr2),
        .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .fault(fault2),
        .cycle_cnt(cycle_cnt2), .instr_cnt(instr_cnt2)
    );

    logic [18:0] act1, act2;
    assign act1 = {pc_wr, pc_src, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, alu_op, fault};
    assign act2 = {pc_wr2, pc_src2, ir_wr2, iord2, mem_rd2, mem_wr2, reg_wr2, reg_dst2,
                   mem_to_reg2, alu_src_a2, alu_src_b2, alu_op2, fault2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
        int          cyc;
        int          ins;
    } vec_t;

    vec_t tbl[$];

    logic [18:0] P_ZERO, P_FW, P_FR, P_DEC, P_EXR_ADD, P_EXR_SUB, P_EXR_OR, P_WBR;
    logic [18:0] P_MADDR, P_MRD, P_MWB, P_MWR, P_BR_T, P_BR_N, P_JAL, P_EXI_XOR;
    logic [18:0] P_WBI, P_JR, P_FLT;

    function automatic logic [18:0] st(input int pw, input int ps, input int irw, input int io,
                                       input int mr, input int mw, input int rw, input int rd,
                                       input int m2, input int a, input int b, input int op,
                                       input int f);
        return {1'(pw), 2'(ps), 1'(irw), 1'(io), 1'(mr), 1'(mw), 1'(rw), 2'(rd),
                2'(m2), 1'(a), 2'(b), 3'(op), 1'(f)};
    endfunction

    task automatic row(input int r, input int o, input int f, input int z, input int y,
                       input logic [18:0] e, input int c, input int n);
        vec_t v;
        v.rst = 1'(r); v.op = 6'(o); v.fn = 6'(f); v.z = 1'(z); v.rdy = 1'(y);
        v.exp = e; v.cyc = c; v.ins = n;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int r, input int o, input int f, input int z, input int y);
        reset = 1'(r); opcode = 6'(o); funct = 6'(f); zero = 1'(z); mem_ready = 1'(y);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        drive(1, 0, 0, 0, 0);
        adv();
        reset = 1'b0;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);

        P_ZERO    = '0;
        P_FW      = st(0,0,0,0,1,0,0,0,0,0,1,0,0);
        P_FR      = st(1,0,1,0,1,0,0,0,0,0,1,0,0);
        P_DEC     = st(0,0,0,0,0,0,0,0,0,0,3,0,0);
        P_EXR_ADD = st(0,0,0,0,0,0,0,0,0,1,0,0,0);
        P_EXR_SUB = st(0,0,0,0,0,0,0,0,0,1,0,1,0);
        P_EXR_OR  = st(0,0,0,0,0,0,0,0,0,1,0,7,0);
        P_WBR     = st(0,0,0,0,0,0,1,1,0,0,0,0,0);
        P_MADDR   = st(0,0,0,0,0,0,0,0,0,1,2,0,0);
        P_MRD     = st(0,0,0,1,1,0,0,0,0,0,0,0,0);
        P_MWB     = st(0,0,0,0,0,0,1,0,1,0,0,0,0);
        P_MWR     = st(0,0,0,1,0,1,0,0,0,0,0,0,0);
        P_BR_T    = st(1,1,0,0,0,0,0,0,0,1,0,1,0);
        P_BR_N    = st(0,1,0,0,0,0,0,0,0,1,0,1,0);
        P_JAL     = st(1,2,0,0,0,0,1,2,2,0,0,0,0);
        P_EXI_XOR = st(0,0,0,0,0,0,0,0,0,1,2,2,0);
        P_WBI     = st(0,0,0,0,0,0,1,0,0,0,0,0,0);
        P_JR      = st(1,3,0,0,0,0,0,0,0,0,0,0,0);
        P_FLT     = st(0,0,0,0,0,0,0,0,0,0,0,0,1);

        //   rst op      fn    z rdy expected    cyc ins
        row(1, OPR,    FADD, 0, 1, P_ZERO,     0, 0);
        row(0, OPR,    FADD, 0, 1, P_FR,       0, 0);
        row(0, OPR,    FADD, 0, 1, P_DEC,      1, 0);
        row(0, OPR,    FADD, 0, 1, P_EXR_ADD,  2, 0);
        row(0, OPR,    FADD, 0, 1, P_WBR,      3, 0);
        row(0, OPR,    FSUB, 0, 1, P_FR,       4, 1);
        row(0, OPR,    FSUB, 0, 1, P_DEC,      5, 1);
        row(0, OPR,    FSUB, 0, 1, P_EXR_SUB,  6, 1);
        row(0, OPR,    FSUB, 0, 1, P_WBR,      7, 1);
        row(0, OPR,    FOR,  0, 1, P_FR,       8, 2);
        row(0, OPR,    FOR,  0, 1, P_DEC,      9, 2);
        row(0, OPR,    FOR,  0, 1, P_EXR_OR,  10, 2);
        row(0, OPR,    FOR,  0, 1, P_WBR,     11, 2);
        row(0, OPLW,   0,    0, 1, P_FR,      12, 3);
        row(0, OPLW,   0,    0, 1, P_DEC,     13, 3);
        row(0, OPLW,   0,    0, 1, P_MADDR,   14, 3);
        row(0, OPLW,   0,    0, 0, P_MRD,     15, 3);
        row(0, OPLW,   0,    0, 0, P_MRD,     16, 3);
        row(0, OPLW,   0,    0, 0, P_MRD,     17, 3);
        row(0, OPLW,   0,    0, 1, P_MRD,     18, 3);
        row(0, OPLW,   0,    0, 1, P_MWB,     19, 3);
        row(0, OPSW,   0,    0, 1, P_FR,      20, 4);
        row(0, OPSW,   0,    0, 1, P_DEC,     21, 4);
        row(0, OPSW,   0,    0, 1, P_MADDR,   22, 4);
        row(0, OPSW,   0,    0, 1, P_MWR,     23, 4);
        row(0, OPBEQ,  0,    1, 1, P_FR,      24, 5);
        row(0, OPBEQ,  0,    1, 1, P_DEC,     25, 5);
        row(0, OPBEQ,  0,    1, 1, P_BR_T,    26, 5);
        row(0, OPBNE,  0,    1, 1, P_FR,      27, 6);
        row(0, OPBNE,  0,    1, 1, P_DEC,     28, 6);
        row(0, OPBNE,  0,    1, 1, P_BR_N,    29, 6);
        row(0, OPBNE,  0,    0, 1, P_FR,      30, 7);
        row(0, OPBNE,  0,    0, 1, P_DEC,     31, 7);
        row(0, OPBNE,  0,    0, 1, P_BR_T,    32, 7);
        row(0, OPJAL,  0,    0, 1, P_FR,      33, 8);
        row(0, OPJAL,  0,    0, 1, P_DEC,     34, 8);
        row(0, OPJAL,  0,    0, 1, P_JAL,     35, 8);
        row(0, OPXORI, 0,    0, 1, P_FR,      36, 9);
        row(0, OPXORI, 0,    0, 1, P_DEC,     37, 9);
        row(0, OPXORI, 0,    0, 1, P_EXI_XOR, 38, 9);
        row(0, OPXORI, 0,    0, 1, P_WBI,     39, 9);
        row(0, OPR,    FJR,  0, 1, P_FR,      40, 10);
        row(0, OPR,    FJR,  0, 1, P_DEC,     41, 10);
        row(0, OPR,    FJR,  0, 1, P_JR,      42, 10);
        row(0, OPBAD,  0,    0, 0, P_FW,      43, 11);
        row(0, OPBAD,  0,    0, 1, P_FR,      44, 11);
        row(0, OPBAD,  0,    0, 1, P_DEC,     45, 11);
        row(0, OPBAD,  0,    0, 1, P_FLT,     46, 11);
        row(0, OPBAD,  0,    0, 1, P_FLT,     46, 11);

        adv();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(int'(tbl[i].rst), int'(tbl[i].op), int'(tbl[i].fn), int'(tbl[i].z), int'(tbl[i].rdy));
            @(negedge clk);
            chk($sformatf("row%0d strobes", i), 64'(act1), 64'(tbl[i].exp));
            chk($sformatf("row%0d cycle_cnt", i), 64'(cycle_cnt), 64'(tbl[i].cyc));
            chk($sformatf("row%0d instr_cnt", i), 64'(instr_cnt), 64'(tbl[i].ins));
            adv();
        end

        // Timeout: ready held low from reset faults in cycle 9 with cycle_cnt frozen at 8.
        rst_pulse();
        for (int k = 1; k <= 8; k++) begin
            drive(0, OPR, FADD, 0, 0);
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), 64'(act1), 64'(P_FW));
            adv();
        end
        @(negedge clk);
        chk("to_fault", 64'(act1), 64'(P_FLT));
        chk("to_cycle", 64'(cycle_cnt), 64'd8);
        adv(); adv(); adv();
        @(negedge clk);
        chk("to_fault_held", 64'(act1), 64'(P_FLT));
        chk("to_cycle_frozen", 64'(cycle_cnt), 64'd8);
        chk("to_instr", 64'(instr_cnt), 64'd0);
        adv();

        // Ready on the limit cycle wins over the timeout.
        rst_pulse();
        for (int k = 1; k <= 7; k++) begin
            drive(0, OPR, FADD, 0, 0);
            adv();
        end
        drive(0, OPR, FADD, 0, 1);
        @(negedge clk);
        chk("limit_ready", 64'(act1), 64'(P_FR));
        adv();
        @(negedge clk);
        chk("limit_decode", 64'(act1), 64'(P_DEC));
        adv();

        // Wait counter restarts in MEM_RD: 5 fetch waits then 7 read waits stay legal.
        rst_pulse();
        for (int k = 1; k <= 5; k++) begin
            drive(0, OPLW, 0, 0, 0);
            adv();
        end
        drive(0, OPLW, 0, 0, 1);
        adv(); adv(); adv();
        for (int k = 1; k <= 7; k++) begin
            drive(0, OPLW, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("rd_wait%0d", k), 64'(act1), 64'(P_MRD));
            adv();
        end
        drive(0, OPLW, 0, 0, 1);
        @(negedge clk);
        chk("rd_limit_ready", 64'(act1), 64'(P_MRD));
        adv();
        @(negedge clk);
        chk("rd_wb", 64'(act1), 64'(P_MWB));
        adv();
        drive(0, OPLW, 0, 0, 0);
        @(negedge clk);
        chk("rd_next_fetch", 64'(act1), 64'(P_FW));
        chk("rd_cycle", 64'(cycle_cnt), 64'd17);
        chk("rd_instr", 64'(instr_cnt), 64'd1);
        adv();

        // jal with and without support.
        rst_pulse();
        drive(0, OPJAL, 0, 0, 1);
        adv();
        @(negedge clk);
        chk("nojal_decode", 64'(act2), 64'(P_DEC));
        adv();
        @(negedge clk);
        chk("jal_strobes", 64'(act1), 64'(P_JAL));
        chk("nojal_fault", 64'(act2), 64'(P_FLT));
        chk("nojal_cycle", 64'(cycle_cnt2), 64'd2);
        adv();
        @(negedge clk);
        chk("jal_instr", 64'(instr_cnt), 64'd1);
        chk("nojal_instr", 64'(instr_cnt2), 64'd0);
        adv();

        // Reset asserted in the middle of a stalled MEM_WR.
        rst_pulse();
        drive(0, OPSW, 0, 0, 1);
        adv(); adv(); adv();
        drive(0, OPSW, 0, 0, 0);
        @(negedge clk);
        chk("sw_memwr", 64'(act1), 64'(P_MWR));
        chk("sw_cycle", 64'(cycle_cnt), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_strobes", 64'(act1), 64'(P_ZERO));
        chk("rst_cycle", 64'(cycle_cnt), 64'd0);
        chk("rst_instr", 64'(instr_cnt), 64'd0);
        adv();
        reset = 1'b0;
        @(negedge clk);
        chk("rel_fetch", 64'(act1), 64'(P_FW));
        chk("rel_cycle", 64'(cycle_cnt), 64'd0);
        chk("rel_instr", 64'(instr_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
